// File: rtl/divisor_sequencial.sv
// rtl/divisor_sequencial.sv - multi-cycle unsigned restoring divider, one subtract step per clock
module divisor_sequencial #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           iniciar,
  input  logic [2*N-1:0] dividendo,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quociente,
  output logic [N-1:0]   resto,
  output logic           ocupado,
  output logic           pronto,
  output logic           erro_div_zero
);

  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

  estado_t        estado;
  logic [N-1:0]   r;
  logic [2*N-1:0] q;
  logic [N-1:0]   d;
  logic [CW-1:0]  cnt;

  logic [N:0]     r_desl;
  logic           sem_emprestimo;
  logic [N-1:0]   r_prox;
  logic [2*N-1:0] q_prox;

  // R < D before every shift, so the partial remainder always fits in N bits
  // once the step is done; only the shifted value needs the extra bit.
  always_comb begin
    r_desl         = {r, q[2*N-1]};
    sem_emprestimo = (r_desl >= {1'b0, d});
    r_prox         = sem_emprestimo ? N'(r_desl - {1'b0, d}) : N'(r_desl);
    q_prox         = {q[2*N-2:0], sem_emprestimo};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= OCIOSO;
      r             <= '0;
      q             <= '0;
      d             <= '0;
      cnt           <= '0;
      quociente     <= '0;
      resto         <= '0;
      erro_div_zero <= 1'b0;
    end else if (estado != CALCULA && iniciar) begin
      if (divisor == '0) begin
        estado        <= FIM;
        quociente     <= '1;
        resto         <= '0;
        erro_div_zero <= 1'b1;
      end else begin
        estado        <= CALCULA;
        d             <= divisor;
        q             <= dividendo;
        r             <= '0;
        cnt           <= '0;
        erro_div_zero <= 1'b0;
      end
    end else if (estado == CALCULA) begin
      r   <= r_prox;
      q   <= q_prox;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(2*N-1)) begin
        estado    <= FIM;
        quociente <= q_prox;
        resto     <= r_prox;
      end
    end
  end

  assign ocupado = (estado == CALCULA);
  assign pronto  = (estado == FIM);

endmodule

// File: tb/tb_divisor_sequencial.sv
// tb/tb_divisor_sequencial.sv - self-checking bench for divisor_sequencial
module tb_divisor_sequencial;

  localparam int N = 4;

  logic           clock;
  logic           reset;
  logic           iniciar;
  logic [2*N-1:0] dividendo;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] quociente;
  logic [N-1:0]   resto;
  logic           ocupado;
  logic           pronto;
  logic           erro_div_zero;

  int compared   = 0;
  int mismatched = 0;

  divisor_sequencial #(.N(N)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .dividendo(dividendo), .divisor(divisor),
    .quociente(quociente), .resto(resto),
    .ocupado(ocupado), .pronto(pronto), .erro_div_zero(erro_div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           e;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, " quociente"}, int'(quociente), 0);
    chk({name, " resto"}, int'(resto), 0);
    chk({name, " ocupado"}, int'(ocupado), 0);
    chk({name, " pronto"}, int'(pronto), 0);
    chk({name, " erro"}, int'(erro_div_zero), 0);
  endtask

  // Launches one operation at the next edge and waits for the result;
  // returns right after the edge where pronto becomes visible.
  task automatic run_op(input string name, input logic [2*N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] eq, input logic [N-1:0] er, input logic ee);
    int busy;
    logic [2*N-1:0] q_antes;
    logic mudou;
    q_antes   = quociente;
    mudou     = 1'b0;
    dividendo = a;
    divisor   = b;
    iniciar   = 1'b1;
    tick();
    iniciar   = 1'b0;
    dividendo = 2*N'($urandom);
    divisor   = N'($urandom);
    if (b != 0) chk({name, " pronto drops on start"}, int'(pronto), 0);
    busy = 0;
    while (ocupado && busy < 30) begin
      busy++;
      if (quociente != q_antes) mudou = 1'b1;
      tick();
    end
    chk({name, " busy cycles"}, busy, (b == 0) ? 0 : 2*N);
    chk({name, " quociente stable while busy"}, int'(mudou), 0);
    chk({name, " pronto"}, int'(pronto), 1);
    chk({name, " quociente"}, int'(quociente), int'(eq));
    chk({name, " resto"}, int'(resto), int'(er));
    chk({name, " erro"}, int'(erro_div_zero), int'(ee));
  endtask

  always @(negedge clock) begin
    if (!reset && ocupado && pronto) begin
      compared++;
      mismatched++;
      $display("FAIL exclusive flags: ocupado=%0d pronto=%0d, required not both 1", ocupado, pronto);
    end
  end

  initial begin
    logic [2*N-1:0] a, mq;
    logic [N-1:0]   b, mr;
    int busy;

    tbl[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
    tbl[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
    tbl[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
    tbl[3] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0};
    tbl[4] = '{8'd13,  4'd0,  8'd255, 4'd0, 1'b1};
    tbl[5] = '{8'd13,  4'd2,  8'd6,   4'd1, 1'b0};

    reset     = 1'b1;
    iniciar   = 1'b0;
    dividendo = '0;
    divisor   = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_reset_state("reset idle");

    run_op("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold quociente", int'(quociente), 28);
      chk("hold resto", int'(resto), 4);
      chk("hold pronto", int'(pronto), 1);
    end

    // back-to-back table: each start issued on the edge after pronto is seen
    for (int i = 0; i < 6; i++)
      run_op($sformatf("table[%0d]", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].e);

    // second iniciar during CALCULA is ignored; operands toggle every cycle
    tick();
    dividendo = 8'd200;
    divisor   = 4'd7;
    iniciar   = 1'b1;
    tick();
    busy = 0;
    for (int c = 1; c < 30 && ocupado; c++) begin
      busy++;
      iniciar = (c == 3);
      if (c == 3) begin
        dividendo = 8'd9;
        divisor   = 4'd3;
      end else begin
        dividendo = 2*N'($urandom);
        divisor   = N'($urandom);
      end
      tick();
    end
    iniciar = 1'b0;
    chk("ignored start busy", busy, 2*N);
    chk("ignored start quociente", int'(quociente), 28);
    chk("ignored start resto", int'(resto), 4);
    chk("ignored start pronto", int'(pronto), 1);

    // reset mid-operation aborts with no partial result
    dividendo = 8'd200;
    divisor   = 4'd7;
    iniciar   = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("abort");
    for (int i = 0; i < 12; i++) tick();
    chk_reset_state("abort stays");
    run_op("100/10", 8'd100, 4'd10, 8'd10, 4'd0, 1'b0);

    // random operations against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      a = 2*N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      if (b == 0) begin
        mq = '1;
        mr = '0;
      end else begin
        mq = a / b;
        mr = N'(a % b);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      run_op($sformatf("rand %0d/%0d", a, b), a, b, mq, mr, (b == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
